// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and constants for the I/D-cache memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } cmd_e;

    // A request with both strobes high is a write.
    function automatic cmd_e req_cmd(input logic rd, input logic wr);
        return wr ? CMD_WRITE : (rd ? CMD_READ : CMD_NONE);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the I and D requests.
// MEM_ARB_RR_EN: ties go to the port not served last; otherwise D always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic i_last,
`endif
    input  logic i_ireq,
    input  logic i_dreq,
    output logic o_valid,
    output logic o_port
);

    assign o_valid = i_ireq | i_dreq;
`ifdef MEM_ARB_RR_EN
    assign o_port = (i_ireq & i_dreq) ? ~i_last : (i_dreq ? PORT_D : PORT_I);
`else
    assign o_port = i_dreq ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide memory port between the I-cache and D-cache.
// MEM_ARB_RR_EN enables round-robin tie breaking; default build is fixed D priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              i_mem_ready,
    output logic [DATA_W-1:0] i_mem_rdata,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic              d_mem_ready,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            r_state;
    state_e            w_next;
    cmd_e              r_cmd;
    cmd_e              w_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata;
    logic              w_valid;
    logic              w_port;
    logic              w_grant;
    logic              w_done;
`ifdef MEM_ARB_RR_EN
    logic              r_last;
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .i_last  (r_last),
`endif
        .i_ireq  (i_mem_read | i_mem_write),
        .i_dreq  (d_mem_read | d_mem_write),
        .o_valid (w_valid),
        .o_port  (w_port)
    );

    assign w_grant = (r_state == ST_IDLE) && w_valid;
    assign w_done  = (r_state != ST_IDLE) && mem_ready;
    assign w_cmd   = (w_port == PORT_D) ? req_cmd(d_mem_read, d_mem_write)
                                        : req_cmd(i_mem_read, i_mem_write);
    assign w_addr  = (w_port == PORT_D) ? d_mem_addr : i_mem_addr;
    assign w_wdata = (w_port == PORT_D) ? d_mem_wdata : i_mem_wdata;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = w_grant ? ((w_port == PORT_D) ? ST_BUSY_D : ST_BUSY_I)
                         : (w_done ? ST_IDLE : r_state);
    end

    always_comb begin
        i_mem_ready = (r_state == ST_BUSY_I) && mem_ready;
        d_mem_ready = (r_state == ST_BUSY_D) && mem_ready;
        mem_read    = (r_cmd == CMD_READ);
        mem_write   = (r_cmd == CMD_WRITE);
    end

    // The shared port is driven only from this snapshot, taken at grant time.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_cmd   <= CMD_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_cmd   <= w_cmd;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end else if (w_done) begin
            r_cmd   <= CMD_NONE;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Reset value makes the D-cache win the first tie.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n)
            r_last <= PORT_I;
        else if (w_done)
            r_last <= (r_state == ST_BUSY_D) ? PORT_D : PORT_I;
    end
`endif

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: arbitration table, directed corner sequences and a randomized run
// checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic ir, iw, dr, dw;
        int   port;
        logic wr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ird = 1'b0, iwr = 1'b0, drd = 1'b0, dwr = 1'b0, mrdy = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [DW-1:0] iwd = '0, dwd = '0, mrdata = '0;
    logic          i_rdy, d_rdy, mrd, mwr;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd, irdata, drdata;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset_n(rst_n),
        .i_mem_read(ird), .i_mem_write(iwr), .i_mem_addr(iaddr), .i_mem_wdata(iwd),
        .i_mem_ready(i_rdy), .i_mem_rdata(irdata),
        .d_mem_read(drd), .d_mem_write(dwr), .d_mem_addr(daddr), .d_mem_wdata(dwd),
        .d_mem_ready(d_rdy), .d_mem_rdata(drdata),
        .mem_read(mrd), .mem_write(mwr), .mem_addr(maddr), .mem_wdata(mwd),
        .mem_rdata(mrdata), .mem_ready(mrdy)
    );

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input string n, input logic r, input logic w, input logic [AW-1:0] a, input bit ad);
        chk({n, " mem_read"}, DW'(mrd), DW'(r));
        chk({n, " mem_write"}, DW'(mwr), DW'(w));
        if (ad) chk({n, " mem_addr"}, DW'(maddr), DW'(a));
    endtask

    task automatic rdy(input string n, input logic ei, input logic ed);
        chk({n, " i_mem_ready"}, DW'(i_rdy), DW'(ei));
        chk({n, " d_mem_ready"}, DW'(d_rdy), DW'(ed));
    endtask

    task automatic quiet();
        ird = 1'b0; iwr = 1'b0; drd = 1'b0; dwr = 1'b0; mrdy = 1'b0;
    endtask

    // 1 = I-cache, 2 = D-cache, 0 = nobody; last is the port served most recently.
    function automatic int pick(input logic ri, input logic rd, input int last);
        if (ri && rd) return (RR && last == 2) ? 1 : 2;
        return ri ? 1 : (rd ? 2 : 0);
    endfunction

    initial begin
        vec_t          vt[8];
        logic [DW-1:0] pat;
        int            owner, mlast, w;
        logic          mw;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        bit            idone, ddone;
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, RR ? 1 : 2, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, RR ? 1 : 2, 1'b1};

        #2 rst_n = 1'b0;
        mrdy = 1'b1;
        #1;
        bus("reset", 1'b0, 1'b0, '0, 1'b1);
        chk("reset mem_wdata", mwd, '0);
        rdy("reset", 1'b0, 1'b0);
        mrdy = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            string n;
            n = $sformatf("vec%0d", k);
            ird = vt[k].ir; iwr = vt[k].iw; drd = vt[k].dr; dwr = vt[k].dw;
            iaddr = AW'(32'h100 + 32'(k));
            daddr = AW'(32'h200 + 32'(k));
            iwd = {4{32'hA0000000 + 32'(k)}};
            dwd = {4{32'hD0000000 + 32'(k)}};
            #1;
            bus({n, " N"}, 1'b0, 1'b0, '0, 1'b0);
            cyc();
            bus(n, vt[k].port != 0 && !vt[k].wr, vt[k].port != 0 && vt[k].wr,
                vt[k].port == 1 ? iaddr : daddr, vt[k].port != 0);
            if (vt[k].port != 0) chk({n, " mem_wdata"}, mwd, vt[k].port == 1 ? iwd : dwd);
            mrdy = 1'b1;
            #1;
            rdy(n, vt[k].port == 1, vt[k].port == 2);
            cyc();
            quiet();
            #1;
            bus({n, " M+1"}, 1'b0, 1'b0, '0, 1'b0);
            cyc();
        end

        pat = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        drd = 1'b1; daddr = 28'h0000123;
        #1;
        bus("rd N", 1'b0, 1'b0, '0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 4) begin
                mrdy = 1'b1;
                mrdata = pat;
            end
            #1;
            bus($sformatf("rd N+%0d", c), 1'b1, 1'b0, 28'h0000123, 1'b1);
            rdy($sformatf("rd N+%0d", c), 1'b0, c == 4);
        end
        chk("rd d_mem_rdata", drdata, pat);
        chk("rd i_mem_rdata", irdata, pat);
        cyc(); quiet(); #1;
        bus("rd M+1", 1'b0, 1'b0, '0, 1'b0);
        cyc();

        pat = {4{32'h11111111}};
        dwr = 1'b1; daddr = 28'h0000040; dwd = pat;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 3) mrdy = 1'b1;
            #1;
            bus("wb", 1'b0, 1'b1, 28'h0000040, 1'b1);
            chk("wb mem_wdata", mwd, pat);
            rdy("wb", 1'b0, c == 3);
        end
        cyc();
        mrdy = 1'b0; dwr = 1'b0; drd = 1'b1; daddr = 28'h0000080; dwd = '0;
        #1;
        bus("wb M+1", 1'b0, 1'b0, '0, 1'b0);
        cyc();
        mrdy = 1'b1;
        #1;
        bus("refill M+2", 1'b1, 1'b0, 28'h0000080, 1'b1);
        rdy("refill", 1'b0, 1'b1);
        cyc(); quiet(); cyc();

        ird = 1'b1; iaddr = 28'h0000321;
        cyc();
        iaddr = 28'h0000FFF;
        #1;
        bus("chg 1", 1'b1, 1'b0, 28'h0000321, 1'b1);
        cyc(); #1;
        bus("chg 2", 1'b1, 1'b0, 28'h0000321, 1'b1);
        cyc();
        mrdy = 1'b1;
        #1;
        bus("chg 3", 1'b1, 1'b0, 28'h0000321, 1'b1);
        rdy("chg", 1'b1, 1'b0);
        cyc(); quiet(); cyc();

        dwr = 1'b1; daddr = 28'h0000555; dwd = pat;
        cyc(); #1;
        bus("rst pre", 1'b0, 1'b1, 28'h0000555, 1'b1);
        #2 rst_n = 1'b0;
        mrdy = 1'b1;
        #1;
        bus("rst mid", 1'b0, 1'b0, '0, 1'b1);
        chk("rst mid mem_wdata", mwd, '0);
        rdy("rst mid", 1'b0, 1'b0);
        quiet();
        cyc();
        #2 rst_n = 1'b1;

        cyc();
        ird = 1'b1; drd = 1'b1; iaddr = 28'h0000AAA; daddr = 28'h0000BBB;
        cyc();
        mrdy = 1'b1;
        #1;
        bus("tie1", 1'b1, 1'b0, 28'h0000BBB, 1'b1);
        rdy("tie1", 1'b0, 1'b1);
        cyc();
        mrdy = 1'b0; drd = 1'b0;
        #1;
        bus("tie1 M+1", 1'b0, 1'b0, '0, 1'b0);
        cyc();
        mrdy = 1'b1;
        #1;
        bus("tie1 M+2", 1'b1, 1'b0, 28'h0000AAA, 1'b1);
        rdy("tie1 M+2", 1'b1, 1'b0);
        cyc();
        quiet(); drd = 1'b1;
        cyc();
        mrdy = 1'b1;
        #1;
        bus("d alone", 1'b1, 1'b0, 28'h0000BBB, 1'b1);
        rdy("d alone", 1'b0, 1'b1);
        cyc(); quiet(); cyc();
        ird = 1'b1; drd = 1'b1;
        cyc();
        mrdy = 1'b1;
        #1;
        bus("tie2", 1'b1, 1'b0, RR ? 28'h0000AAA : 28'h0000BBB, 1'b1);
        rdy("tie2", RR, !RR);
        cyc(); quiet(); cyc();

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        owner = 0; mlast = 1; idone = 1'b0; ddone = 1'b0;
        mw = 1'b0; ma = '0; md = '0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            iaddr = AW'($urandom); daddr = AW'($urandom);
            iwd = {$urandom, $urandom, $urandom, $urandom};
            dwd = {$urandom, $urandom, $urandom, $urandom};
            mrdata = {$urandom, $urandom, $urandom, $urandom};
            if (owner != 1) {iwr, ird} = (idone || $urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if (owner != 2) {dwr, drd} = (ddone || $urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            idone = 1'b0; ddone = 1'b0;
            mrdy = (owner != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            #1;
            bus("rnd", owner != 0 && !mw, owner != 0 && mw, ma, owner != 0);
            if (owner != 0) chk("rnd mem_wdata", mwd, md);
            rdy("rnd", mrdy && owner == 1, mrdy && owner == 2);
            chk("rnd i_mem_rdata", irdata, mrdata);
            chk("rnd d_mem_rdata", drdata, mrdata);
            if (owner == 0) begin
                w = pick(ird | iwr, drd | dwr, mlast);
                if (w == 1) begin
                    owner = 1; mw = iwr; ma = iaddr; md = iwd;
                end else if (w == 2) begin
                    owner = 2; mw = dwr; ma = daddr; md = dwd;
                end
            end else if (mrdy) begin
                idone = (owner == 1);
                ddone = (owner == 2);
                mlast = owner;
                owner = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
